instr_fetch_rv: RTL and testbench
=================================

// Module: instr_fetch_rv
// PURPOSE
//  Upstream fetch stage for the RV32I execute decoder. Owns the PC and runs the req/ack handshake to instruction memory.
//  Presents one instruction at a time (orInstr/orPc/orOldPc) and holds it until the execute side retires it.
//  On retire, computes the next PC from the execute decoder's orNextPcSrc/imm outputs plus ALU/reg1 data.
// PARAMETERS
//  RESET_VECTOR  32'h00000000  PC loaded on reset; first fetch address
//  NOP_INSTR     32'h00000013  value driven on orInstr when no valid instr (addi x0,x0,0)
// PORTS
//  iwClk               in   1   clock, rising edge
//  iwnRst              in   1   asynchronous, active-low reset
//  orIMemAddr          out  32  fetch address; stable while orIMemReq=1 and no ack
//  orIMemReq           out  1   fetch request
//  iwIMemAck           in   1   memory accepts request and returns data this cycle
//  iwIMemData          in   32  instruction word, sampled when req&&ack
//  iwIMemErr           in   1   bus error, sampled when req&&ack
//  orInstr             out  32  instruction to execute decoder (NOP_INSTR unless valid)
//  orPc                out  32  address of presented instruction (AUIPC base)
//  orOldPc             out  32  address of presented instruction (link/branch base)
//  orInstrValid        out  1   orInstr is a real fetched instruction
//  iwRetire            in   1   execute consumes presented instruction this cycle
//  iwNextPcSrc         in   2   `NEXT_PC_SRC_SEQ/JAL/JALR/B from execute decoder
//  iwNextPcImmediate20 in   20  JAL offset[20:1]
//  iwNextPcImmediate12 in   12  JALR offset[11:0] / branch offset[12:1]
//  iwBranchInverted    in   1   invert branch condition
//  iwAluResult0        in   1   ALU result bit 0 (EQ/SLT/SLTU outcome)
//  iwReg1Data          in   32  rs1 value for JALR
//  orFetchFault        out  1   sticky: bus error or misaligned target; fetch halted
// BEHAVIOUR
//  Reset (async, iwnRst=0): state=S_IDLE, PC=RESET_VECTOR, orIMemReq=0, orInstrValid=0, orInstr=NOP_INSTR,
//   orPc=orOldPc=RESET_VECTOR, orIMemAddr=RESET_VECTOR, orFetchFault=0. In-flight request dropped immediately.
//  FSM: S_IDLE -> S_REQ unconditionally (one idle cycle after reset release).
//   S_REQ: orIMemReq=1, orIMemAddr=PC. On ack&&!err: latch data, -> S_VALID next cycle. On ack&&err: -> S_FAULT.
//   S_VALID: orInstrValid=1, orInstr=latched word, orPc=orOldPc=PC. Held indefinitely until iwRetire=1.
//    On retire: PC<=target (below), -> S_REQ; if target[1:0]!=0 -> S_FAULT, PC<=target (reported PC).
//   S_FAULT: orFetchFault=1, orIMemReq=0, orInstrValid=0, orInstr=NOP_INSTR; exit only by reset.
//  Min throughput: 2 cycles/instr (ack in first S_REQ cycle, retire in first S_VALID cycle).
//  Target computation (mod 2^32, combinational from inputs, registered on retire):
//   SEQ : PC+4 (32'hFFFFFFFC wraps to 0)
//   JAL : PC + sext32({imm20,1'b0})
//   JALR: (iwReg1Data + sext32(imm12)) & ~32'h1
//   B   : taken = iwAluResult0 ^ iwBranchInverted; taken ? PC + sext32({imm12,1'b0}) : PC+4
//  iwIMemAck ignored outside S_REQ; iwRetire ignored outside S_VALID (no PC change).
//  Next-PC inputs sampled only on retire edge; changes at other times have no effect.
//  No speculative/overlapping fetch: at most one outstanding request.
// TESTING
//  T1 reset: RESET_VECTOR=0x100; release reset, ack at once -> req on 2nd cycle, addr 0x100, valid next cycle.
//  T2 seq + wait states: ack delayed 3 cycles -> addr/req held stable; retire SEQ -> next addr 0x104; wrap 0xFFFFFFFC->0x0.
//  T3 JAL imm20=0xFFFFE at PC 0x200 -> next 0x1FC; JALR rs1=0x1003,imm12=0x004 -> next 0x1006 (bit0 cleared, aligned? no: 0x1006 misaligned -> fault).
//  T4 branch: PC 0x300,imm12=0x008; aluRes0=1,inv=0 -> 0x310; aluRes0=1,inv=1 -> 0x304.
//  T5 iwIMemErr with ack -> orFetchFault=1, req stays 0, orInstr=0x00000013 until reset.
//  T6 assert iwnRst mid S_REQ (no ack) -> req drops same cycle, refetch from RESET_VECTOR after release.

Source files
------------

// File: rtl/instr_fetch_rv_if.sv
// Instruction-memory request bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_rv_if;
    logic [31:0] orIMemAddr;
    logic        orIMemReq;
    logic        iwIMemAck;
    logic [31:0] iwIMemData;
    logic        iwIMemErr;

    modport master (output orIMemAddr, orIMemReq, input iwIMemAck, iwIMemData, iwIMemErr);
    modport slave  (input orIMemAddr, orIMemReq, output iwIMemAck, iwIMemData, iwIMemErr);
endinterface

// File: rtl/instr_fetch_rv.sv
// RV32I fetch stage: owns the PC, fetches one word at a time over a req/ack bus and
// holds it for the execute side until retired, then steers to the decoded next PC.
module instr_fetch_rv #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                   iwClk,
    input  logic                   iwnRst,
    instr_fetch_rv_if.master       imem,
    output logic [31:0]            orInstr,
    output logic [31:0]            orPc,
    output logic [31:0]            orOldPc,
    output logic                   orInstrValid,
    input  logic                   iwRetire,
    input  logic [1:0]             iwNextPcSrc,
    input  logic [19:0]            iwNextPcImmediate20,
    input  logic [11:0]            iwNextPcImmediate12,
    input  logic                   iwBranchInverted,
    input  logic                   iwAluResult0,
    input  logic [31:0]            iwReg1Data,
    output logic                   orFetchFault
);
    localparam logic [1:0] NEXT_PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] NEXT_PC_SRC_JAL  = 2'd1;
    localparam logic [1:0] NEXT_PC_SRC_JALR = 2'd2;
    localparam logic [1:0] NEXT_PC_SRC_B    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] seqPc;
    logic [31:0] target;
    logic        taken;

    always_comb begin
        seqPc  = pc + 32'd4;
        taken  = iwAluResult0 ^ iwBranchInverted;
        target = seqPc;
        case (iwNextPcSrc)
            NEXT_PC_SRC_SEQ:  target = seqPc;
            NEXT_PC_SRC_JAL:  target = pc + {{11{iwNextPcImmediate20[19]}}, iwNextPcImmediate20, 1'b0};
            NEXT_PC_SRC_JALR: target = (iwReg1Data + {{20{iwNextPcImmediate12[11]}}, iwNextPcImmediate12})
                                       & ~32'h1;
            NEXT_PC_SRC_B:    target = taken ? pc + {{19{iwNextPcImmediate12[11]}}, iwNextPcImmediate12, 1'b0}
                                             : seqPc;
            default:          target = seqPc;
        endcase
    end

    // The presented instruction always sits at the current PC, so both PC views share the register.
    assign orPc    = pc;
    assign orOldPc = pc;

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state           <= S_IDLE;
            pc              <= RESET_VECTOR;
            imem.orIMemReq  <= 1'b0;
            imem.orIMemAddr <= RESET_VECTOR;
            orInstrValid    <= 1'b0;
            orInstr         <= NOP_INSTR;
            orFetchFault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state           <= S_REQ;
                    imem.orIMemReq  <= 1'b1;
                    imem.orIMemAddr <= pc;
                end
                S_REQ: begin
                    if (imem.iwIMemAck) begin
                        imem.orIMemReq <= 1'b0;
                        if (imem.iwIMemErr) begin
                            state        <= S_FAULT;
                            orFetchFault <= 1'b1;
                        end else begin
                            state        <= S_VALID;
                            orInstr      <= imem.iwIMemData;
                            orInstrValid <= 1'b1;
                        end
                    end
                end
                S_VALID: begin
                    if (iwRetire) begin
                        pc           <= target;
                        orInstrValid <= 1'b0;
                        orInstr      <= NOP_INSTR;
                        // A misaligned target is reported through orPc rather than fetched.
                        if (target[1:0] != 2'b00) begin
                            state        <= S_FAULT;
                            orFetchFault <= 1'b1;
                        end else begin
                            state           <= S_REQ;
                            imem.orIMemReq  <= 1'b1;
                            imem.orIMemAddr <= target;
                        end
                    end
                end
                S_FAULT: begin
                    imem.orIMemReq <= 1'b0;
                    orInstrValid   <= 1'b0;
                    orInstr        <= NOP_INSTR;
                    orFetchFault   <= 1'b1;
                end
                default: state <= S_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_rv.sv
// Scoreboard bench for instr_fetch_rv: retires push expected fetch addresses, bus requests pop them.
module tb_instr_fetch_rv;
    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b0;
    logic [31:0] orInstr, orPc, orOldPc;
    logic        orInstrValid, orFetchFault;
    logic        iwRetire = 1'b0;
    logic [1:0]  iwNextPcSrc = 2'd0;
    logic [19:0] iwNextPcImmediate20 = '0;
    logic [11:0] iwNextPcImmediate12 = '0;
    logic        iwBranchInverted = 1'b0;
    logic        iwAluResult0 = 1'b0;
    logic [31:0] iwReg1Data = '0;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] expQ[$];
    logic [31:0] curPc = RV;

    always #5 iwClk = ~iwClk;

    instr_fetch_rv_if bus();

    instr_fetch_rv #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
        .iwClk(iwClk), .iwnRst(iwnRst), .imem(bus),
        .orInstr(orInstr), .orPc(orPc), .orOldPc(orOldPc), .orInstrValid(orInstrValid),
        .iwRetire(iwRetire), .iwNextPcSrc(iwNextPcSrc),
        .iwNextPcImmediate20(iwNextPcImmediate20), .iwNextPcImmediate12(iwNextPcImmediate12),
        .iwBranchInverted(iwBranchInverted), .iwAluResult0(iwAluResult0),
        .iwReg1Data(iwReg1Data), .orFetchFault(orFetchFault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] pc, input logic [1:0] src,
                                          input logic [19:0] i20, input logic [11:0] i12,
                                          input logic inv, input logic alu, input logic [31:0] rs1);
        int o;
        case (src)
            2'd0: return pc + 32'd4;
            2'd1: begin o = $signed({i20, 1'b0}); return pc + 32'(o); end
            2'd2: begin o = $signed(i12); return (rs1 + 32'(o)) & 32'hFFFF_FFFE; end
            default: begin
                o = $signed({i12, 1'b0});
                return (alu != inv) ? pc + 32'(o) : pc + 32'd4;
            end
        endcase
    endfunction

    task automatic waitReq(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge iwClk);
            if (bus.orIMemReq) begin
                n = i + 1;
                return;
            end
        end
        check("reqTimeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        iwnRst = 1'b0;
        expQ.delete();
        repeat (2) @(negedge iwClk);
        check("rstReq", bus.orIMemReq, 32'd0);
        check("rstValid", orInstrValid, 32'd0);
        check("rstInstr", orInstr, NOP);
        check("rstPc", orPc, RV);
        check("rstOldPc", orOldPc, RV);
        check("rstAddr", bus.orIMemAddr, RV);
        check("rstFault", orFetchFault, 32'd0);
        iwnRst = 1'b1;
        expQ.push_back(RV);
    endtask

    // Serve one fetch with `waits` wait states; retire pulses during the wait must be ignored.
    task automatic fetch(input int waits, input logic err, output int n);
        logic [31:0] a, w;
        waitReq(n);
        if (n < 0) return;
        if (expQ.size() == 0) begin
            check("queueEmpty", 32'd0, 32'd1);
            a = bus.orIMemAddr;
        end else begin
            a = expQ.pop_front();
        end
        check("fetchAddr", bus.orIMemAddr, a);
        curPc = a;
        for (int i = 0; i < waits; i++) begin
            iwRetire = 1'b1;
            iwNextPcSrc = 2'd1;
            iwNextPcImmediate20 = 20'($urandom);
            @(negedge iwClk);
            iwRetire = 1'b0;
            check("holdReq", bus.orIMemReq, 32'd1);
            check("holdAddr", bus.orIMemAddr, a);
        end
        w = a ^ 32'hA5A5_0003;
        bus.iwIMemAck = 1'b1;
        bus.iwIMemData = w;
        bus.iwIMemErr = err;
        @(negedge iwClk);
        bus.iwIMemAck = 1'b0;
        bus.iwIMemErr = 1'b0;
        bus.iwIMemData = $urandom;
        check("ackReqDrop", bus.orIMemReq, 32'd0);
        if (err) begin
            check("errFault", orFetchFault, 32'd1);
            check("errValid", orInstrValid, 32'd0);
            check("errInstr", orInstr, NOP);
        end else begin
            check("valid", orInstrValid, 32'd1);
            check("instr", orInstr, w);
            check("pc", orPc, a);
            check("oldPc", orOldPc, a);
        end
    endtask

    // Hold the instruction `hold` cycles (with stray acks/errors), then retire it.
    task automatic retire(input int hold, input logic [1:0] src, input logic [19:0] i20,
                          input logic [11:0] i12, input logic inv, input logic alu,
                          input logic [31:0] rs1);
        logic [31:0] exp;
        for (int i = 0; i < hold; i++) begin
            bus.iwIMemAck = 1'b1;
            bus.iwIMemErr = 1'b1;
            @(negedge iwClk);
            bus.iwIMemAck = 1'b0;
            bus.iwIMemErr = 1'b0;
            check("heldValid", orInstrValid, 32'd1);
            check("heldNoFault", orFetchFault, 32'd0);
            check("heldPc", orPc, curPc);
        end
        exp = model(curPc, src, i20, i12, inv, alu, rs1);
        iwRetire = 1'b1;
        iwNextPcSrc = src;
        iwNextPcImmediate20 = i20;
        iwNextPcImmediate12 = i12;
        iwBranchInverted = inv;
        iwAluResult0 = alu;
        iwReg1Data = rs1;
        @(negedge iwClk);
        iwRetire = 1'b0;
        iwNextPcSrc = 2'($urandom);
        iwNextPcImmediate20 = 20'($urandom);
        iwNextPcImmediate12 = 12'($urandom);
        iwReg1Data = $urandom;
        check("retireValid", orInstrValid, 32'd0);
        check("retirePc", orPc, exp);
        if (exp[1:0] != 2'b00) begin
            check("misalignFault", orFetchFault, 32'd1);
            check("misalignReq", bus.orIMemReq, 32'd0);
        end else begin
            expQ.push_back(exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] src;
        bus.iwIMemAck = 1'b0;
        bus.iwIMemData = '0;
        bus.iwIMemErr = 1'b0;

        // Reset and first fetch timing
        doReset();
        fetch(0, 1'b0, n);
        check("firstReqCycle", n, 32'd1);

        // Sequential with wait states, held instruction, ignored acks
        retire(3, 2'd0, '0, '0, 1'b0, 1'b0, '0);
        fetch(3, 1'b0, n);
        retire(0, 2'd2, '0, 12'h000, 1'b0, 1'b0, 32'h0000_0200);
        fetch(0, 1'b0, n);
        retire(0, 2'd1, 20'hFFFFE, '0, 1'b0, 1'b0, '0);
        fetch(1, 1'b0, n);
        check("jalTarget", curPc, 32'h0000_01FC);

        // Branches
        retire(0, 2'd2, '0, 12'h003, 1'b0, 1'b0, 32'h0000_02FD);
        fetch(0, 1'b0, n);
        retire(0, 2'd3, '0, 12'h008, 1'b0, 1'b1, '0);
        fetch(0, 1'b0, n);
        check("brTaken", curPc, 32'h0000_0310);
        retire(0, 2'd3, '0, 12'h008, 1'b1, 1'b1, '0);
        fetch(0, 1'b0, n);
        retire(0, 2'd3, '0, 12'hFF8, 1'b1, 1'b0, '0);
        fetch(0, 1'b0, n);

        // Wrap at top of address space
        retire(0, 2'd2, '0, 12'h004, 1'b0, 1'b0, 32'hFFFF_FFF8);
        fetch(0, 1'b0, n);
        retire(0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
        fetch(2, 1'b0, n);
        check("wrapAddr", curPc, 32'h0000_0000);

        // JALR to misaligned target
        retire(0, 2'd2, '0, 12'h004, 1'b0, 1'b0, 32'h0000_1003);
        repeat (3) @(negedge iwClk);
        check("faultSticky", orFetchFault, 32'd1);
        check("faultPc", orPc, 32'h0000_1006);

        // Random aligned traffic
        doReset();
        fetch(0, 1'b0, n);
        for (int i = 0; i < 10; i++) begin
            src = 2'($urandom);
            retire($urandom_range(0, 2), src, 20'($urandom) & 20'hFFFFE, 12'($urandom) & 12'hFFC,
                   1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC);
            fetch($urandom_range(0, 3), 1'b0, n);
        end

        // Bus error
        retire(0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
        fetch(1, 1'b1, n);
        repeat (3) begin
            iwRetire = 1'b1;
            @(negedge iwClk);
            iwRetire = 1'b0;
            check("errHoldFault", orFetchFault, 32'd1);
            check("errHoldReq", bus.orIMemReq, 32'd0);
            check("errHoldInstr", orInstr, NOP);
        end

        // Reset mid-request
        doReset();
        fetch(0, 1'b0, n);
        retire(0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
        waitReq(n);
        iwnRst = 1'b0;
        #1;
        check("asyncReqDrop", bus.orIMemReq, 32'd0);
        check("asyncAddr", bus.orIMemAddr, RV);
        doReset();
        fetch(0, 1'b0, n);
        check("refetchAddr", curPc, RV);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
